// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle MIPS control unit.
//   state_t           controller states
//   aluop_t           coarse ALU request from the FSM to mc_alu_dec
//   OP_* / FN_*       instruction opcode and R-type funct fields
//   ALU_*             alucontrol codes
//   PCSRC_*/ALUSRCB_* datapath mux select encodings
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB, S_EXEC,
    S_ALUWB, S_ADDIEX, S_IMMWB, S_BRANCH, S_JUMP, S_JAL, S_ERROR
  } state_t;

  typedef enum logic [1:0] {AO_ADD, AO_SUB, AO_FUNCT} aluop_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: maps the FSM's ALU request plus funct to a 3-bit alucontrol.
//   aluop          in  AO_ADD / AO_SUB force the operation, AO_FUNCT decodes funct
//   funct          in  instr[5:0]
//   alucontrol     out 3-bit ALU operation code
//   funct_illegal  out funct not recognised (only meaningful for AO_FUNCT)
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      AO_ADD: alucontrol = ALU_ADD;
      AO_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control unit (state machine + ALU decode) with
// a memory ready handshake and per-access wait timeout.
//   clk, reset        clock, asynchronous active-low reset
//   opcode, funct     IR fields; zero = ALU zero flag; mem_ready = access done
//   memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, alucontrol: datapath selects
//   irwrite, memwrite, pcen, regwrite: strobes, forced low while reset is low
//   mem_timeout, illegal: sticky error flags, cleared only by reset
// Build option: define MC_CTRL_JAL_EN to decode opcode 000011 as JAL;
// otherwise that opcode is illegal.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W   = 3,
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 memtoreg,
  output logic [1:0]           regdst,
  output logic                 iord,
  output logic [1:0]           pcsrc,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 irwrite,
  output logic                 memwrite,
  output logic                 pcen,
  output logic                 regwrite,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 mem_timeout,
  output logic                 illegal
);

  state_t            state, state_n;
  logic [WAIT_W-1:0] wait_cnt;
  aluop_t            aluop;
  logic [2:0]        alu3;
  logic              funct_illegal;
  logic              irw, memw, pce, regw;
  logic              set_ill, set_tmo;
  logic              waiting, tmo_hit;

  mc_alu_dec u_alu_dec (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (alu3),
    .funct_illegal (funct_illegal)
  );

  assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // Limit cycle: counter already at the limit and memory still not ready.
  assign tmo_hit = (wait_cnt == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state)
        wait_cnt <= '0;
      else if (waiting && !mem_ready && wait_cnt != '1)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (set_ill) illegal     <= 1'b1;
      if (set_tmo) mem_timeout <= 1'b1;
    end
  end

  // Controls not named for a state stay at 0 / add.
  always_comb begin
    state_n  = state;
    aluop    = AO_ADD;
    memtoreg = 1'b0;
    regdst   = 2'b00;
    iord     = 1'b0;
    pcsrc    = PCSRC_ALU;
    alusrca  = 1'b0;
    alusrcb  = ALUSRCB_B;
    irw      = 1'b0;
    memw     = 1'b0;
    pce      = 1'b0;
    regw     = 1'b0;
    set_ill  = 1'b0;
    set_tmo  = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb = ALUSRCB_FOUR;
        irw     = mem_ready;
        pce     = mem_ready;
        if (mem_ready)    state_n = S_DECODE;
        else if (tmo_hit) begin state_n = S_ERROR; set_tmo = 1'b1; end
      end
      S_DECODE: begin
        alusrcb = ALUSRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW:   state_n = S_MEMADR;
          OP_R:           state_n = S_EXEC;
          OP_BEQ, OP_BNE: state_n = S_BRANCH;
          OP_ADDI:        state_n = S_ADDIEX;
          OP_J:           state_n = S_JUMP;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:         state_n = S_JAL;
`endif
          default: begin state_n = S_ERROR; set_ill = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        state_n = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready)    state_n = S_MEMWB;
        else if (tmo_hit) begin state_n = S_ERROR; set_tmo = 1'b1; end
      end
      S_MEMWR: begin
        iord = 1'b1;
        memw = 1'b1;
        if (mem_ready)    state_n = S_FETCH;
        else if (tmo_hit) begin state_n = S_ERROR; set_tmo = 1'b1; end
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regw     = 1'b1;
        state_n  = S_FETCH;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = AO_FUNCT;
        if (funct_illegal) begin state_n = S_ERROR; set_ill = 1'b1; end
        else                     state_n = S_ALUWB;
      end
      S_ALUWB: begin
        regdst  = 2'b01;
        regw    = 1'b1;
        state_n = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        state_n = S_IMMWB;
      end
      S_IMMWB: begin
        regw    = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = AO_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pce     = (opcode == OP_BNE) ? ~zero : zero;
        state_n = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pce     = 1'b1;
        state_n = S_FETCH;
      end
`ifdef MC_CTRL_JAL_EN
      // Link value PC+4 reaches r31 through the datapath's own link path.
      S_JAL: begin
        regdst  = 2'b10;
        pcsrc   = PCSRC_JUMP;
        pce     = 1'b1;
        regw    = 1'b1;
        state_n = S_FETCH;
      end
`endif
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_ERROR;
    endcase
  end

  // Reset clears state asynchronously, but FETCH's strobes follow mem_ready,
  // so gate with reset to keep every strobe quiet while it is held.
  assign irwrite  = irw  & reset;
  assign memwrite = memw & reset;
  assign pcen     = pce  & reset;
  assign regwrite = regw & reset;

  always_comb begin
    alucontrol      = '0;
    alucontrol[2:0] = alu3;
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven check of the multicycle control unit, plus
// hand sequences for memory stalls, timeout, illegal opcodes and reset.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  localparam int MT = 12;

  logic       clk = 1'b0, reset = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       memtoreg, iord, alusrca, irwrite, memwrite, pcen, regwrite;
  logic       mem_timeout, illegal;
  logic [1:0] regdst, pcsrc, alusrcb;
  logic [2:0] alucontrol;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALUCTRL_W(3), .WAIT_W(4), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .memtoreg(memtoreg), .regdst(regdst), .iord(iord),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .irwrite(irwrite),
    .memwrite(memwrite), .pcen(pcen), .regwrite(regwrite),
    .alucontrol(alucontrol), .mem_timeout(mem_timeout), .illegal(illegal)
  );

  typedef struct packed {
    logic       memtoreg;
    logic [1:0] regdst;
    logic       iord;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       irwrite, memwrite, pcen, regwrite;
    logic [2:0] aluc;
    logic       tmo, ill;
  } out_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       z, r;
    out_t       exp;
    string      nm;
  } vec_t;

  out_t got;
  assign got = {memtoreg, regdst, iord, pcsrc, alusrca, alusrcb, irwrite,
                memwrite, pcen, regwrite, alucontrol, mem_timeout, illegal};

  int   checks = 0, failures = 0;
  vec_t vq[$];

  function automatic out_t mk(logic m2r, logic [1:0] rd, logic io, logic [1:0] ps,
                              logic sa, logic [1:0] sb, logic irw, logic mw,
                              logic pe, logic rw, logic [2:0] ac);
    out_t o;
    o = '{m2r, rd, io, ps, sa, sb, irw, mw, pe, rw, ac, 1'b0, 1'b0};
    return o;
  endfunction

  out_t E_FR, E_FW, E_DEC, E_ADR, E_MRD, E_MWR, E_MWB, E_AWB, E_AIX, E_IWB;
  out_t E_BT, E_BN, E_JMP, E_ERR_T, E_ERR_I, E_JAL;

  task automatic check(input string nm, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b", nm, got, exp);
    end
  endtask

  // Apply inputs just after the falling edge and let them settle before comparing.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic r);
    @(negedge clk);
    opcode = op; funct = fn; zero = z; mem_ready = r;
    #1;
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic r, input out_t exp, input string nm);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.r = r; v.exp = exp; v.nm = nm;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; mem_ready = 1'b1;
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    logic [5:0] fns [5];
    logic [2:0] acs [5];
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    acs = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};

    E_FR  = mk(0, 2'b00, 0, 2'b00, 0, 2'b01, 1, 0, 1, 0, ALU_ADD);
    E_FW  = mk(0, 2'b00, 0, 2'b00, 0, 2'b01, 0, 0, 0, 0, ALU_ADD);
    E_DEC = mk(0, 2'b00, 0, 2'b00, 0, 2'b11, 0, 0, 0, 0, ALU_ADD);
    E_ADR = mk(0, 2'b00, 0, 2'b00, 1, 2'b10, 0, 0, 0, 0, ALU_ADD);
    E_MRD = mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 0, 0, ALU_ADD);
    E_MWR = mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 1, 0, 0, ALU_ADD);
    E_MWB = mk(1, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1, ALU_ADD);
    E_AWB = mk(0, 2'b01, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1, ALU_ADD);
    E_AIX = mk(0, 2'b00, 0, 2'b00, 1, 2'b10, 0, 0, 0, 0, ALU_ADD);
    E_IWB = mk(0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1, ALU_ADD);
    E_BT  = mk(0, 2'b00, 0, 2'b01, 1, 2'b00, 0, 0, 1, 0, ALU_SUB);
    E_BN  = mk(0, 2'b00, 0, 2'b01, 1, 2'b00, 0, 0, 0, 0, ALU_SUB);
    E_JMP = mk(0, 2'b00, 0, 2'b10, 0, 2'b00, 0, 0, 1, 0, ALU_ADD);
    E_JAL = mk(0, 2'b10, 0, 2'b10, 0, 2'b00, 0, 0, 1, 1, ALU_ADD);
    E_ERR_T = mk(0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, ALU_ADD);
    E_ERR_T.tmo = 1'b1;
    E_ERR_I = mk(0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, ALU_ADD);
    E_ERR_I.ill = 1'b1;

    // lw, zero-wait: 5 cycles, write-back only in the last
    add(OP_LW, 0, 0, 1, E_FR,  "lw_fetch");
    add(OP_LW, 0, 0, 1, E_DEC, "lw_decode");
    add(OP_LW, 0, 0, 1, E_ADR, "lw_memadr");
    add(OP_LW, 0, 0, 1, E_MRD, "lw_memrd");
    add(OP_LW, 0, 0, 1, E_MWB, "lw_memwb");
    // branches: pcen follows zero for beq, ~zero for bne
    add(OP_BEQ, 0, 1, 1, E_FR,  "beq1_fetch");
    add(OP_BEQ, 0, 1, 1, E_DEC, "beq1_decode");
    add(OP_BEQ, 0, 1, 1, E_BT,  "beq_taken");
    add(OP_BEQ, 0, 0, 1, E_FR,  "beq0_fetch");
    add(OP_BEQ, 0, 0, 1, E_DEC, "beq0_decode");
    add(OP_BEQ, 0, 0, 1, E_BN,  "beq_not_taken");
    add(OP_BNE, 0, 1, 1, E_FR,  "bne1_fetch");
    add(OP_BNE, 0, 1, 1, E_DEC, "bne1_decode");
    add(OP_BNE, 0, 1, 1, E_BN,  "bne_not_taken");
    add(OP_BNE, 0, 0, 1, E_FR,  "bne0_fetch");
    add(OP_BNE, 0, 0, 1, E_DEC, "bne0_decode");
    add(OP_BNE, 0, 0, 1, E_BT,  "bne_taken");
    // R-type: every funct through EXEC
    for (int i = 0; i < 5; i++) begin
      add(OP_R, fns[i], 0, 1, E_FR,  "r_fetch");
      add(OP_R, fns[i], 0, 1, E_DEC, "r_decode");
      add(OP_R, fns[i], 0, 1, mk(0, 2'b00, 0, 2'b00, 1, 2'b00, 0, 0, 0, 0, acs[i]), "r_exec");
      add(OP_R, fns[i], 0, 1, E_AWB, "r_aluwb");
    end
    add(OP_J,    0, 0, 1, E_FR,  "j_fetch");
    add(OP_J,    0, 0, 1, E_DEC, "j_decode");
    add(OP_J,    0, 0, 1, E_JMP, "j_jump");
    add(OP_ADDI, 0, 0, 1, E_FR,  "addi_fetch");
    add(OP_ADDI, 0, 0, 1, E_DEC, "addi_decode");
    add(OP_ADDI, 0, 0, 1, E_AIX, "addi_exec");
    add(OP_ADDI, 0, 0, 1, E_IWB, "addi_wb");
    add(OP_SW,   0, 0, 1, E_FR,  "sw_fetch");
    add(OP_SW,   0, 0, 1, E_DEC, "sw_decode");
    add(OP_SW,   0, 0, 1, E_ADR, "sw_memadr");
    add(OP_SW,   0, 0, 1, E_MWR, "sw_memwr");

    // Reset held with mem_ready=1: FETCH selects, but no strobe
    reset = 1'b0; mem_ready = 1'b1; opcode = OP_LW;
    @(negedge clk); #1;
    check("reset_state", E_FW);
    @(negedge clk); reset = 1'b1;

    // Table run; each instruction returns to FETCH for the next
    foreach (vq[i]) begin
      if (i == 0) #1; else step(vq[i].op, vq[i].fn, vq[i].z, vq[i].r);
      if (i == 0) begin opcode = vq[i].op; funct = vq[i].fn; zero = vq[i].z; mem_ready = vq[i].r; #1; end
      check(vq[i].nm, vq[i].exp);
    end

    // Fetch stalls 3 cycles; irwrite/pcen only on the 4th
    for (int i = 0; i < 3; i++) begin
      step(OP_J, 0, 0, 0); check("fetch_stall", E_FW);
    end
    step(OP_J, 0, 0, 1); check("fetch_ready", E_FR);
    step(OP_J, 0, 0, 1); check("stall_j_decode", E_DEC);
    step(OP_J, 0, 0, 1); check("stall_j_jump", E_JMP);

    // MEMRD never ready: timeout on the limit cycle, ERROR sticks
    step(OP_LW, 0, 0, 1); check("tmo_fetch", E_FR);
    step(OP_LW, 0, 0, 1); check("tmo_decode", E_DEC);
    step(OP_LW, 0, 0, 1); check("tmo_memadr", E_ADR);
    for (int i = 0; i <= MT; i++) begin
      step(OP_LW, 0, 0, 0); check("tmo_memrd_wait", E_MRD);
    end
    step(OP_LW, 0, 0, 1); check("tmo_error", E_ERR_T);
    step(OP_LW, 0, 0, 1); check("tmo_error_hold", E_ERR_T);
    step(OP_J,  0, 1, 0); check("tmo_error_hold2", E_ERR_T);
    do_reset();

    // Ready arrives on the limit cycle: no timeout
    #1; opcode = OP_LW; #1; check("edge_fetch", E_FR);
    step(OP_LW, 0, 0, 1); check("edge_decode", E_DEC);
    step(OP_LW, 0, 0, 1); check("edge_memadr", E_ADR);
    for (int i = 0; i < MT; i++) begin
      step(OP_LW, 0, 0, 0); check("edge_memrd_wait", E_MRD);
    end
    step(OP_LW, 0, 0, 1); check("edge_memrd_limit", E_MRD);
    step(OP_LW, 0, 0, 1); check("edge_memwb", E_MWB);

    // Illegal opcode
    step(6'b111111, 0, 0, 1); check("ill_fetch", E_FR);
    step(6'b111111, 0, 0, 1); check("ill_decode", E_DEC);
    step(6'b111111, 0, 0, 1); check("ill_error", E_ERR_I);
    step(OP_J,      0, 0, 1); check("ill_error_hold", E_ERR_I);
    do_reset();

    // Illegal funct on an R-type ends in ERROR too
    #1; opcode = OP_R; funct = 6'b111111; #1; check("badfn_fetch", E_FR);
    step(OP_R, 6'b111111, 0, 1);
    step(OP_R, 6'b111111, 0, 1);
    step(OP_R, 6'b111111, 0, 1); check("badfn_error", E_ERR_I);
    do_reset();

    // Reset mid-MEMWR: memwrite drops at once, FETCH afterwards
    #1; opcode = OP_SW; funct = 0; #1; check("rst_sw_fetch", E_FR);
    step(OP_SW, 0, 0, 1); check("rst_sw_decode", E_DEC);
    step(OP_SW, 0, 0, 1); check("rst_sw_memadr", E_ADR);
    step(OP_SW, 0, 0, 0); check("rst_sw_memwr", E_MWR);
    #1; reset = 1'b0; #1; check("rst_memwr_drop", E_FW);
    @(negedge clk); reset = 1'b1; mem_ready = 1'b1; #1;
    check("rst_release_fetch", E_FR);

    // Opcode 000011
    step(OP_JAL, 0, 0, 1); check("jal_decode", E_DEC);
    step(OP_JAL, 0, 0, 1);
`ifdef MC_CTRL_JAL_EN
    check("jal_state", E_JAL);
    step(OP_J, 0, 0, 1); check("jal_back_fetch", E_FR);
`else
    check("jal_illegal", E_ERR_I);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
